// File: rtl/glay_setup_cache_responder_pkg.sv
// Shared types for the kernel-setup memory responder: request/response packets,
// command encodings and the responder FSM state type.
package glay_setup_cache_responder_pkg;

    localparam int unsigned SETUP_LINE_BYTES  = 64;
    localparam int unsigned SETUP_LINE_BITS   = SETUP_LINE_BYTES * 8;
    localparam int unsigned SETUP_OFFSET_BITS = 6;
    localparam int unsigned SETUP_ADDR_BITS   = 64;
    localparam int unsigned SETUP_ID_BITS     = 8;
    localparam int unsigned SETUP_CMD_BITS    = 2;

    typedef logic [SETUP_CMD_BITS-1:0] setup_cmd_t;

    localparam setup_cmd_t CMD_NOP   = 2'd0;
    localparam setup_cmd_t CMD_READ  = 2'd1;
    localparam setup_cmd_t CMD_WRITE = 2'd2;

    typedef enum logic [1:0] {
        RSP_RESET = 2'd0,
        RSP_INIT  = 2'd1,
        RSP_READY = 2'd2
    } responder_state;

    typedef struct packed {
        setup_cmd_t                 cmd;
        logic [SETUP_ID_BITS-1:0]   id;
        logic [SETUP_ADDR_BITS-1:0] address;
    } memory_meta_t;

    typedef struct packed {
        memory_meta_t               meta;
        logic [SETUP_LINE_BITS-1:0] data;
    } memory_request_payload_t;

    typedef struct packed {
        logic                    valid;
        memory_request_payload_t payload;
    } memory_request_packet_t;

    typedef struct packed {
        memory_meta_t               meta;
        logic [SETUP_LINE_BITS-1:0] data;
        logic                       error;
    } memory_response_payload_t;

    typedef struct packed {
        logic                     valid;
        memory_response_payload_t payload;
    } memory_response_packet_t;

endpackage

// File: rtl/glay_setup_resp_fifo.sv
// Show-ahead synchronous FIFO of response payloads.
//  clk, rst_n  clock, async active-low reset
//  push/push_data  write one entry (caller guarantees space)
//  pop         retire the head entry (ignored when empty)
//  head        current head entry, valid whenever count != 0
//  count       number of stored entries
module glay_setup_resp_fifo
    import glay_setup_cache_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  memory_response_payload_t         push_data,
    input  logic                             pop,
    output memory_response_payload_t         head,
    output logic [$clog2(DEPTH + 1)-1:0]     count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    memory_response_payload_t mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic                     rd_en;

    assign rd_en = pop && (count != '0);
    assign head  = mem[rd_ptr];

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/glay_setup_cache_responder.sv
// Memory-side responder for the kernel-setup request path. Serves cacheline
// reads/writes from an internal line store with fixed two-cycle latency and
// returns responses in acceptance order through a credit-managed FIFO.
//  ap_clk, ap_rst_n    clock, async active-low reset
//  req_in/req_in_ready request handshake (valid inside req_in)
//  resp_out/resp_out_ready response handshake (valid inside resp_out)
//  fifo_setup_signal   high while resetting / zero-filling the store
//  stat_reads/writes/errors  saturating counts of popped responses
module glay_setup_cache_responder
    import glay_setup_cache_responder_pkg::*;
#(
    parameter int unsigned                NUM_LINES       = 16,
    parameter int unsigned                LINE_BITS       = SETUP_LINE_BITS,
    parameter logic [SETUP_ADDR_BITS-1:0] BASE_ADDRESS    = 64'h0,
    parameter int unsigned                RESP_FIFO_DEPTH = 8,
    parameter int unsigned                COUNTER_WIDTH   = 32
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  memory_request_packet_t       req_in,
    output logic                         req_in_ready,
    output memory_response_packet_t      resp_out,
    input  logic                         resp_out_ready,
    output logic                         fifo_setup_signal,
    output logic [COUNTER_WIDTH-1:0]     stat_reads,
    output logic [COUNTER_WIDTH-1:0]     stat_writes,
    output logic [COUNTER_WIDTH-1:0]     stat_errors
);

    // NUM_LINES must be a power of two >= 2; LINE_BITS must equal the packet line width.
    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned CNT_W  = $clog2(RESP_FIFO_DEPTH + 1);
    localparam int unsigned HI_LSB = SETUP_OFFSET_BITS + IDX_W;

    responder_state           state;
    logic [IDX_W-1:0]         init_idx;
    logic [CNT_W-1:0]         outstanding;
    logic [CNT_W-1:0]         next_out;
    logic                     accept;
    logic                     pop;

    logic [SETUP_ADDR_BITS:0] req_diff;
    logic [IDX_W-1:0]         req_line;
    logic                     req_err;

    logic                     s1_valid;
    memory_meta_t             s1_meta;
    logic [IDX_W-1:0]         s1_line;
    logic                     s1_err;
    logic [LINE_BITS-1:0]     s1_data;

    logic                     s2_valid;
    memory_meta_t             s2_meta;
    logic                     s2_err;
    logic [LINE_BITS-1:0]     s2_rdata;

    logic [LINE_BITS-1:0]     line_mem [NUM_LINES];

    memory_response_payload_t push_data;
    memory_response_payload_t fifo_head;
    logic [CNT_W-1:0]         fifo_count;

    assign accept = req_in.valid && req_in_ready;
    assign pop    = resp_out.valid && resp_out_ready;

    always_comb begin
        resp_out.valid   = (fifo_count != '0);
        resp_out.payload = fifo_head;
    end

    // Address decode; the extra top bit of the difference flags addresses below the base
    always_comb begin
        req_diff = {1'b0, req_in.payload.meta.address} - {1'b0, BASE_ADDRESS};
        req_line = req_diff[SETUP_OFFSET_BITS +: IDX_W];
        req_err  = req_diff[SETUP_ADDR_BITS]
                || (req_diff[SETUP_OFFSET_BITS-1:0] != '0)
                || (req_diff[SETUP_ADDR_BITS-1:HI_LSB] != '0)
                || ((req_in.payload.meta.cmd != CMD_READ) && (req_in.payload.meta.cmd != CMD_WRITE));
    end

    // Credits: everything accepted but not yet popped, whether in flight or queued
    always_comb begin
        next_out = outstanding + CNT_W'(accept) - CNT_W'(pop);
    end

    // Responder FSM with registered ready and setup flag
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state             <= RSP_RESET;
            init_idx          <= '0;
            outstanding       <= '0;
            fifo_setup_signal <= 1'b1;
            req_in_ready      <= 1'b0;
        end else begin
            outstanding <= next_out;
            case (state)
                RSP_RESET: begin
                    state    <= RSP_INIT;
                    init_idx <= '0;
                end
                RSP_INIT: begin
                    init_idx <= init_idx + 1'b1;
                    if (init_idx == IDX_W'(NUM_LINES - 1)) begin
                        state             <= RSP_READY;
                        fifo_setup_signal <= 1'b0;
                        req_in_ready      <= 1'b1;
                    end
                end
                RSP_READY: begin
                    req_in_ready <= (next_out < CNT_W'(RESP_FIFO_DEPTH));
                end
                default: begin
                    state <= RSP_RESET;
                end
            endcase
        end
    end

    // Stage 1: capture the decoded request
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_valid <= 1'b0;
            s1_meta  <= '0;
            s1_line  <= '0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_meta <= req_in.payload.meta;
                s1_line <= req_line;
                s1_err  <= req_err;
                s1_data <= req_in.payload.data;
            end
        end
    end

    // Stage 2 control; the line data comes from the store below
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s2_valid <= 1'b0;
            s2_meta  <= '0;
            s2_err   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_meta  <= s1_meta;
            s2_err   <= s1_err;
        end
    end

    // Line store: zero-fill during init, otherwise commit writes from stage 1.
    // A write commits one edge before a following read samples the store, so
    // back-to-back write/read of a line returns the new data.
    always_ff @(posedge ap_clk) begin
        if (state == RSP_INIT) begin
            line_mem[init_idx] <= '0;
        end else if (s1_valid && !s1_err && (s1_meta.cmd == CMD_WRITE)) begin
            line_mem[s1_line] <= s1_data;
        end
        s2_rdata <= line_mem[s1_line];
    end

    // Only successful reads carry data back
    always_comb begin
        push_data.meta  = s2_meta;
        push_data.error = s2_err;
        push_data.data  = (!s2_err && (s2_meta.cmd == CMD_READ)) ? s2_rdata : '0;
    end

    glay_setup_resp_fifo #(
        .DEPTH (RESP_FIFO_DEPTH)
    ) u_resp_fifo (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .push      (s2_valid),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Saturating statistics, counted as responses leave
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_errors <= '0;
        end else if (pop) begin
            if (resp_out.payload.error) begin
                if (stat_errors != '1) stat_errors <= stat_errors + 1'b1;
            end else if (resp_out.payload.meta.cmd == CMD_READ) begin
                if (stat_reads != '1) stat_reads <= stat_reads + 1'b1;
            end else if (resp_out.payload.meta.cmd == CMD_WRITE) begin
                if (stat_writes != '1) stat_writes <= stat_writes + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_glay_setup_cache_responder.sv
// Self-checking bench for glay_setup_cache_responder: a scoreboard predicts every
// accepted request's response and compares it as the response is popped.
`timescale 1ns/1ps
module tb_glay_setup_cache_responder;
    import glay_setup_cache_responder_pkg::*;

    localparam int unsigned NUM_LINES = 16;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned CW        = 32;
    localparam logic [63:0] BASE      = 64'h0;

    logic                    ap_clk = 1'b0;
    logic                    ap_rst_n = 1'b0;
    memory_request_packet_t  req_in;
    logic                    req_in_ready;
    memory_response_packet_t resp_out;
    logic                    resp_out_ready;
    logic                    fifo_setup_signal;
    logic [CW-1:0]           stat_reads;
    logic [CW-1:0]           stat_writes;
    logic [CW-1:0]           stat_errors;

    always #5 ap_clk = ~ap_clk;

    glay_setup_cache_responder #(
        .NUM_LINES       (NUM_LINES),
        .LINE_BITS       (SETUP_LINE_BITS),
        .BASE_ADDRESS    (BASE),
        .RESP_FIFO_DEPTH (DEPTH),
        .COUNTER_WIDTH   (CW)
    ) dut (
        .ap_clk            (ap_clk),
        .ap_rst_n          (ap_rst_n),
        .req_in            (req_in),
        .req_in_ready      (req_in_ready),
        .resp_out          (resp_out),
        .resp_out_ready    (resp_out_ready),
        .fifo_setup_signal (fifo_setup_signal),
        .stat_reads        (stat_reads),
        .stat_writes       (stat_writes),
        .stat_errors       (stat_errors)
    );

    int n_checks = 0;
    int n_pass   = 0;
    memory_response_payload_t   exp_q[$];
    logic [SETUP_LINE_BITS-1:0] model_mem [NUM_LINES];
    int exp_reads  = 0;
    int exp_writes = 0;
    int exp_errors = 0;
    logic [7:0] next_id = 8'd0;

    // Reference model: predict the response and apply writes to the model store
    function automatic memory_response_payload_t predict(input memory_request_payload_t rq);
        memory_response_payload_t r;
        logic [63:0] a;
        logic [3:0]  idx;
        logic        bad;
        a   = rq.meta.address;
        idx = a[9:6];
        bad = (a[5:0] != 6'd0) || (a >= BASE + 64'(NUM_LINES * 64))
           || ((rq.meta.cmd != CMD_READ) && (rq.meta.cmd != CMD_WRITE));
        r.meta  = rq.meta;
        r.error = bad;
        r.data  = '0;
        if (!bad && rq.meta.cmd == CMD_READ) r.data = model_mem[idx];
        if (!bad && rq.meta.cmd == CMD_WRITE) model_mem[idx] = rq.data;
        return r;
    endfunction

    // Scoreboard monitor, sampling on the inactive edge
    always @(negedge ap_clk) begin : mon
        memory_response_payload_t e;
        if (ap_rst_n) begin
            if (resp_out.valid && resp_out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL resp_unexpected: got id=%0h addr=%0h, required no response",
                             resp_out.payload.meta.id, resp_out.payload.meta.address);
                end else begin
                    e = exp_q.pop_front();
                    if (resp_out.payload !== e) begin
                        $display("FAIL resp_payload id=%0h: got cmd=%0d err=%0b addr=%0h data=%h, required id=%0h cmd=%0d err=%0b addr=%0h data=%h",
                                 resp_out.payload.meta.id, resp_out.payload.meta.cmd, resp_out.payload.error,
                                 resp_out.payload.meta.address, resp_out.payload.data,
                                 e.meta.id, e.meta.cmd, e.error, e.meta.address, e.data);
                    end else begin
                        n_pass++;
                    end
                    if (e.error) exp_errors++;
                    else if (e.meta.cmd == CMD_READ) exp_reads++;
                    else exp_writes++;
                end
            end
            if (req_in.valid && req_in_ready) exp_q.push_back(predict(req_in.payload));
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_req(input logic v, input setup_cmd_t c, input logic [63:0] a,
                           input logic [SETUP_LINE_BITS-1:0] d, input logic [7:0] id);
        req_in.valid                = v;
        req_in.payload.meta.cmd     = c;
        req_in.payload.meta.id      = id;
        req_in.payload.meta.address = a;
        req_in.payload.data         = d;
    endtask

    // Present one request and hold it until it is taken
    task automatic send(input setup_cmd_t c, input logic [63:0] a, input logic [SETUP_LINE_BITS-1:0] d);
        set_req(1'b1, c, a, d, next_id);
        next_id++;
        for (int t = 0; t < 100 && !req_in_ready; t++) tick();
        if (!req_in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: got req_in_ready=0 after 100 cycles, required 1");
        end
        tick();
        req_in.valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || resp_out.valid) && t < 300) begin
            tick();
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0 || resp_out.valid)
            $display("FAIL drain: got %0d responses pending, required 0", exp_q.size());
        else
            n_pass++;
    endtask

    task automatic release_and_count(output int cyc);
        ap_rst_n = 1'b1;
        cyc = 0;
        while (fifo_setup_signal && cyc < 100) begin
            cyc++;
            tick();
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_LINES; i++) model_mem[i] = '0;
        exp_q.delete();
        exp_reads  = 0;
        exp_writes = 0;
        exp_errors = 0;
    endtask

    task automatic test_reset();
        int cyc;
        clear_model();
        ap_rst_n = 1'b0;
        resp_out_ready = 1'b1;
        set_req(1'b0, CMD_NOP, 64'h0, '0, 8'h0);
        repeat (3) tick();
        n_checks++;
        if (req_in_ready !== 1'b0) $display("FAIL reset_ready: got %b, required 0", req_in_ready); else n_pass++;
        n_checks++;
        if (resp_out.valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", resp_out.valid); else n_pass++;
        n_checks++;
        if (fifo_setup_signal !== 1'b1) $display("FAIL reset_setup: got %b, required 1", fifo_setup_signal); else n_pass++;
        n_checks++;
        if ({stat_reads, stat_writes, stat_errors} !== '0)
            $display("FAIL reset_stats: got %0d/%0d/%0d, required 0/0/0", stat_reads, stat_writes, stat_errors);
        else n_pass++;
        release_and_count(cyc);
        n_checks++;
        if (cyc != NUM_LINES + 1) $display("FAIL init_cycles: got %0d, required %0d", cyc, NUM_LINES + 1); else n_pass++;
        n_checks++;
        if (req_in_ready !== 1'b1) $display("FAIL ready_after_init: got %b, required 1", req_in_ready); else n_pass++;
        send(CMD_READ, 64'h0, '0);
        drain();
    endtask

    task automatic test_write_readback();
        logic [SETUP_LINE_BITS-1:0] a5;
        a5 = {64{8'hA5}};
        resp_out_ready = 1'b1;
        n_checks++;
        if (req_in_ready !== 1'b1) $display("FAIL wr_ready: got %b, required 1", req_in_ready); else n_pass++;
        set_req(1'b1, CMD_WRITE, 64'h40, a5, next_id);
        next_id++;
        tick();
        set_req(1'b1, CMD_READ, 64'h40, '0, next_id);
        next_id++;
        tick();
        req_in.valid = 1'b0;
        n_checks++;
        if (resp_out.valid !== 1'b0) $display("FAIL wr_latency_early: got valid=%b, required 0", resp_out.valid); else n_pass++;
        tick();
        n_checks++;
        if (resp_out.valid !== 1'b1 || resp_out.payload.meta.cmd !== CMD_WRITE || resp_out.payload.data !== '0)
            $display("FAIL write_resp_k2: got valid=%b cmd=%0d, required valid=1 cmd=%0d zero data",
                     resp_out.valid, resp_out.payload.meta.cmd, CMD_WRITE);
        else n_pass++;
        tick();
        n_checks++;
        if (resp_out.valid !== 1'b1 || resp_out.payload.meta.cmd !== CMD_READ || resp_out.payload.data !== a5)
            $display("FAIL read_bypass: got valid=%b cmd=%0d data=%h, required valid=1 cmd=%0d data=%h",
                     resp_out.valid, resp_out.payload.meta.cmd, resp_out.payload.data, CMD_READ, a5);
        else n_pass++;
        drain();
    endtask

    task automatic test_errors();
        send(CMD_READ, 64'h41, '0);
        send(CMD_READ, BASE + 64'(NUM_LINES * 64), '0);
        send(CMD_WRITE, 64'h41, {64{8'h3C}});
        send(CMD_NOP, 64'h80, '0);
        send(CMD_READ, 64'h40, '0);
        drain();
        n_checks++;
        if (stat_errors !== 32'd4) $display("FAIL err_count: got %0d, required 4", stat_errors); else n_pass++;
        n_checks++;
        if (stat_reads !== CW'(exp_reads) || stat_writes !== CW'(exp_writes))
            $display("FAIL err_other_stats: got r=%0d w=%0d, required r=%0d w=%0d", stat_reads, stat_writes, exp_reads, exp_writes);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int   sent;
        logic will;
        sent = 0;
        resp_out_ready = 1'b0;
        set_req(1'b1, CMD_READ, 64'h0, '0, 8'h80);
        for (int cyc = 0; cyc < 20 && sent < 10; cyc++) begin
            will = req_in_ready;
            tick();
            if (will) begin
                sent++;
                set_req(1'b1, CMD_READ, 64'((sent % 16) * 64), '0, 8'(8'h80 + sent));
            end
        end
        n_checks++;
        if (sent != DEPTH) $display("FAIL bp_accepted: got %0d, required %0d", sent, DEPTH); else n_pass++;
        n_checks++;
        if (req_in_ready !== 1'b0) $display("FAIL bp_ready: got %b, required 0", req_in_ready); else n_pass++;
        n_checks++;
        if (resp_out.valid !== 1'b1 || resp_out.payload.meta.id !== 8'h80)
            $display("FAIL bp_head: got valid=%b id=%0h, required valid=1 id=80", resp_out.valid, resp_out.payload.meta.id);
        else n_pass++;
        resp_out_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && sent < 10; cyc++) begin
            will = req_in_ready;
            tick();
            if (will) begin
                sent++;
                set_req(1'b1, CMD_READ, 64'((sent % 16) * 64), '0, 8'(8'h80 + sent));
            end
        end
        req_in.valid = 1'b0;
        n_checks++;
        if (sent != 10) $display("FAIL bp_total: got %0d, required 10", sent); else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        int drops;
        int reads_before;
        drops = 0;
        reads_before = exp_reads;
        resp_out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            set_req(1'b1, CMD_READ, 64'((i % 16) * 64), '0, next_id);
            next_id++;
            if (!req_in_ready) drops++;
            tick();
        end
        req_in.valid = 1'b0;
        n_checks++;
        if (drops != 0) $display("FAIL stream_ready: got %0d stalled cycles, required 0", drops); else n_pass++;
        drain();
        n_checks++;
        if (stat_reads !== CW'(reads_before + 100))
            $display("FAIL stream_reads: got %0d, required %0d", stat_reads, reads_before + 100);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int cyc;
        int stale;
        resp_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(CMD_READ, 64'(i * 64), '0);
        tick();
        tick();
        n_checks++;
        if (resp_out.valid !== 1'b1) $display("FAIL mr_pending: got valid=%b, required 1", resp_out.valid); else n_pass++;
        ap_rst_n = 1'b0;
        #1;
        n_checks++;
        if (resp_out.valid !== 1'b0 || req_in_ready !== 1'b0 || fifo_setup_signal !== 1'b1)
            $display("FAIL mr_outputs: got valid=%b ready=%b setup=%b, required 0/0/1",
                     resp_out.valid, req_in_ready, fifo_setup_signal);
        else n_pass++;
        n_checks++;
        if ({stat_reads, stat_writes, stat_errors} !== '0)
            $display("FAIL mr_stats: got %0d/%0d/%0d, required 0/0/0", stat_reads, stat_writes, stat_errors);
        else n_pass++;
        clear_model();
        resp_out_ready = 1'b1;
        tick();
        tick();
        release_and_count(cyc);
        n_checks++;
        if (cyc != NUM_LINES + 1) $display("FAIL mr_init_cycles: got %0d, required %0d", cyc, NUM_LINES + 1); else n_pass++;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            if (resp_out.valid) stale++;
            tick();
        end
        n_checks++;
        if (stale != 0) $display("FAIL mr_stale: got %0d valid cycles, required 0", stale); else n_pass++;
        send(CMD_READ, 64'h40, '0);
        drain();
        n_checks++;
        if (stat_reads !== 32'd1) $display("FAIL mr_reads: got %0d, required 1", stat_reads); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_readback();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
